dyn_branch_predict: RTL
=======================

DYN_BRANCH_PREDICT -- requirements
Module: dyn_branch_predict

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, 32, fetch/branch address width.
REQ-002 SHALL have parameter INDEX_BITS, 8, table index width; DEPTH = 2^INDEX_BITS entries.
REQ-003 SHALL have parameter TAG_BITS, 10, stored tag width, taken from pc[INDEX_BITS+2+TAG_BITS-1 : INDEX_BITS+2].
REQ-004 SHALL have parameter RAS_DEPTH, 4, return-address-stack entries (power of two, >=2).
REQ-005 SHALL have port cpu_clk  in  1  sole clock; all state on rising edge.
REQ-006 SHALL have port cpu_rst  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port flush  in  1  invalidate all predictor state.
REQ-008 SHALL have port next_pc  in  ADDR_WIDTH  lookup address, sampled this cycle.
REQ-009 SHALL have port pc  in  ADDR_WIDTH  fetch address one cycle after next_pc, compared against the tag.
REQ-010 SHALL have port predict_taken  out  1  redirect fetch.
REQ-011 SHALL have port predict_target_pc  out  ADDR_WIDTH  redirect address.
REQ-012 SHALL have port upd_valid  in  1  resolved branch from execute.
REQ-013 SHALL have port upd_pc  in  ADDR_WIDTH  resolved branch address.
REQ-014 SHALL have port upd_taken  in  1  resolved direction.
REQ-015 SHALL have port upd_target  in  ADDR_WIDTH  resolved target.
REQ-016 SHALL have port upd_is_call  in  1  branch is a call; qualified by upd_valid.
REQ-017 SHALL have port upd_is_ret  in  1  branch is a return; qualified by upd_valid.

Function
REQ-018 Per entry SHALL hold valid, tag, target, 2-bit counter ctr, is_ret flag; index = addr[INDEX_BITS+1:2].
REQ-019 Lookup SHALL be registered: entry indexed by next_pc in cycle N drives outputs in N+1 against pc.
REQ-020 hit SHALL = valid && stored tag == pc tag field.
REQ-021 predict_taken SHALL = hit && (is_ret ? ras_count!=0 : ctr[1]).
REQ-022 predict_target_pc SHALL = RAS top when hit && is_ret, else stored target; value irrelevant when predict_taken=0.
REQ-023 Update on hit (tag match at upd index): ctr saturating +1 if upd_taken, -1 otherwise (00 floor, 11 ceiling); target and is_ret rewritten.
REQ-024 Update on miss with upd_taken=1 SHALL allocate: valid=1, new tag, target, is_ret, ctr=2'b10; miss with upd_taken=0 SHALL leave the table unchanged.
REQ-025 Lookup and update at same index in same cycle SHALL return pre-update contents (read-before-write).
REQ-026 RAS push on upd_is_call SHALL store upd_pc+4 (modulo 2^ADDR_WIDTH); pop on upd_is_ret.
REQ-027 RAS push when full SHALL overwrite oldest entry (circular pointer), count stays RAS_DEPTH.
REQ-028 RAS pop when empty SHALL be a no-op.
REQ-029 upd_is_call and upd_is_ret together SHALL replace top of stack (count unchanged; push if empty).
REQ-030 flush SHALL clear all valid bits and RAS count at next edge; flush SHALL take priority over a same-cycle update.
REQ-031 Registered lookup in the cycle after flush SHALL report a miss.

Reset
REQ-032 cpu_rst SHALL asynchronously clear all valid bits, ctr to 2'b01, RAS pointer and count to 0, lookup register to 0.
REQ-033 During and after reset, until first allocation, predict_taken SHALL be 0 and predict_target_pc 0.
REQ-034 Reset mid-update SHALL discard that update.

Structure
REQ-035 Counter encodings (SNT=00, WNT=01, WT=10, ST=11) and tag/index field helpers SHALL live in shared package bp_pkg.
REQ-036 RAS SHALL be sub-module bp_ras (push, pop, replace, flush, top, count).
REQ-037 Table arrays SHALL map to synchronous-read memory; valid bits SHALL be flops.

Verification
REQ-038 Reset, lookup 0x100 -> predict_taken=0, target=0.
REQ-039 upd taken 0x100->0x200, then next_pc=0x100 -> next cycle predict_taken=1, target=0x200; two not-taken updates -> predict_taken=0.
REQ-040 Alias: allocate 0x100, lookup 0x100+(DEPTH*4) -> tag mismatch, predict_taken=0.
REQ-041 Five calls from 0x1000,0x1010,... with RAS_DEPTH=4, ret entry hit -> targets 0x1044,0x1034,0x1024,0x1014, then predict_taken=0 (empty).
REQ-042 flush concurrent with allocating update -> following lookup of that pc misses; same-index lookup+update -> old ctr observed.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and field helpers for the dynamic branch predictor.
// Holds counter encodings and address slicing used by table and bench.
package bp_pkg;

    // 2-bit saturating direction counter
    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    // Table index: addr[ib+1:2], returned zero-extended
    function automatic logic [63:0] bp_index(input logic [63:0] addr,
                                             input int unsigned ib);
        return (addr >> 2) & ((64'd1 << ib) - 64'd1);
    endfunction

    // Tag field: addr[ib+2+tb-1 : ib+2], returned zero-extended
    function automatic logic [63:0] bp_tag(input logic [63:0] addr,
                                           input int unsigned ib,
                                           input int unsigned tb);
        return (addr >> (ib + 2)) & ((64'd1 << tb) - 64'd1);
    endfunction

    // Saturating increment, ceiling at strongly taken
    function automatic ctr_e ctr_inc(input ctr_e c);
        ctr_e r;
        case (c)
            CTR_SNT: r = CTR_WNT;
            CTR_WNT: r = CTR_WT;
            default: r = CTR_ST;
        endcase
        return r;
    endfunction

    // Saturating decrement, floor at strongly not-taken
    function automatic ctr_e ctr_dec(input ctr_e c);
        ctr_e r;
        case (c)
            CTR_ST:  r = CTR_WT;
            CTR_WT:  r = CTR_WNT;
            default: r = CTR_SNT;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/bp_ras.sv
// Circular return-address stack with push, pop and replace-top.
// A push when full overwrites the oldest entry; pop when empty is ignored.
module bp_ras
    import bp_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int RAS_DEPTH  = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          flush_i,
    input  logic                          push_i,
    input  logic                          pop_i,
    input  logic [ADDR_WIDTH-1:0]         data_i,
    output logic [ADDR_WIDTH-1:0]         top_o,
    output logic [$clog2(RAS_DEPTH):0]    count_o
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_WIDTH-1:0] stack_q [RAS_DEPTH];
    logic [PW-1:0]         ptr_q;
    logic [PW-1:0]         ptr_d;
    logic [PW-1:0]         top_idx;
    logic [PW-1:0]         wr_idx;
    logic [CW-1:0]         cnt_q;
    logic [CW-1:0]         cnt_d;
    logic                  wr_en;
    logic                  empty;
    logic                  full;

    assign top_idx = ptr_q - PW'(1);
    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(RAS_DEPTH));

    // Next pointer/count and write slot; ptr_q is the next free slot
    always_comb begin
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        wr_en  = 1'b0;
        wr_idx = ptr_q;
        if (flush_i) begin
            ptr_d = '0;
            cnt_d = '0;
        end else if (push_i && pop_i) begin
            wr_en = 1'b1;
            if (empty) begin
                ptr_d = ptr_q + PW'(1);
                cnt_d = CW'(1);
            end else begin
                wr_idx = top_idx;
            end
        end else if (push_i) begin
            wr_en = 1'b1;
            ptr_d = ptr_q + PW'(1);
            if (!full) begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (pop_i && !empty) begin
            ptr_d = top_idx;
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Stack storage and pointer registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            if (wr_en) begin
                stack_q[wr_idx] <= data_i;
            end
        end
    end

    assign top_o   = stack_q[top_idx];
    assign count_o = cnt_q;

endmodule

// File: rtl/dyn_branch_predict.sv
// Tagged 2-bit-counter branch predictor with a return-address stack.
// Lookup is registered: next_pc indexes this cycle, pc tag-checks next.
module dyn_branch_predict
    import bp_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int INDEX_BITS = 8,
    parameter int TAG_BITS   = 10,
    parameter int RAS_DEPTH  = 4
) (
    input  logic                  cpu_clk,
    input  logic                  cpu_rst,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] next_pc,
    input  logic [ADDR_WIDTH-1:0] pc,
    output logic                  predict_taken,
    output logic [ADDR_WIDTH-1:0] predict_target_pc,
    input  logic                  upd_valid,
    input  logic [ADDR_WIDTH-1:0] upd_pc,
    input  logic                  upd_taken,
    input  logic [ADDR_WIDTH-1:0] upd_target,
    input  logic                  upd_is_call,
    input  logic                  upd_is_ret
);

    localparam int DEPTH  = 1 << INDEX_BITS;
    localparam int RAS_CW = $clog2(RAS_DEPTH) + 1;

    // Valid, tag and counter are flops: the update path needs them
    // combinationally; target/is_ret are synchronous-read memory.
    logic [DEPTH-1:0]      valid_q;
    logic [TAG_BITS-1:0]   tag_q [DEPTH];
    ctr_e                  ctr_q [DEPTH];
    logic [ADDR_WIDTH-1:0] tgt_mem [DEPTH];
    logic                  ret_mem [DEPTH];

    logic                  rd_valid_q;
    logic [TAG_BITS-1:0]   rd_tag_q;
    ctr_e                  rd_ctr_q;
    logic [ADDR_WIDTH-1:0] rd_tgt_q;
    logic                  rd_ret_q;

    logic [INDEX_BITS-1:0] rd_idx;
    logic [INDEX_BITS-1:0] up_idx;
    logic [TAG_BITS-1:0]   pc_tag;
    logic [TAG_BITS-1:0]   up_tag;
    logic                  up_hit;
    logic                  tbl_we;
    ctr_e                  up_ctr;
    logic                  hit;

    logic [ADDR_WIDTH-1:0] ras_top;
    logic [RAS_CW-1:0]     ras_cnt;
    logic                  unused_addr;

    assign rd_idx = INDEX_BITS'(bp_index(64'(next_pc), INDEX_BITS));
    assign up_idx = INDEX_BITS'(bp_index(64'(upd_pc), INDEX_BITS));
    assign pc_tag = TAG_BITS'(bp_tag(64'(pc), INDEX_BITS, TAG_BITS));
    assign up_tag = TAG_BITS'(bp_tag(64'(upd_pc), INDEX_BITS, TAG_BITS));

    assign unused_addr = ^{next_pc, pc, upd_pc};

    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    assign tbl_we = upd_valid && !flush && (up_hit || upd_taken);
    assign up_ctr = !up_hit   ? CTR_WT :
                    upd_taken ? ctr_inc(ctr_q[up_idx]) :
                                ctr_dec(ctr_q[up_idx]);

    // Valid/tag/counter state; flush wins over a same-cycle update
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= '0;
                ctr_q[i] <= CTR_WNT;
            end
        end else if (flush) begin
            valid_q <= '0;
        end else if (tbl_we) begin
            valid_q[up_idx] <= 1'b1;
            tag_q[up_idx]   <= up_tag;
            ctr_q[up_idx]   <= up_ctr;
        end
    end

    // Target/is_ret memory write port; no write while in reset
    always_ff @(posedge cpu_clk) begin
        if (tbl_we && !cpu_rst) begin
            tgt_mem[up_idx] <= upd_target;
            ret_mem[up_idx] <= upd_is_ret;
        end
    end

    // Registered lookup; old contents are read on a same-index update
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            rd_valid_q <= 1'b0;
            rd_tag_q   <= '0;
            rd_ctr_q   <= CTR_WNT;
            rd_tgt_q   <= '0;
            rd_ret_q   <= 1'b0;
        end else begin
            rd_valid_q <= valid_q[rd_idx] && !flush;
            rd_tag_q   <= tag_q[rd_idx];
            rd_ctr_q   <= ctr_q[rd_idx];
            rd_tgt_q   <= tgt_mem[rd_idx];
            rd_ret_q   <= ret_mem[rd_idx];
        end
    end

    bp_ras #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RAS_DEPTH  (RAS_DEPTH)
    ) u_ras (
        .clk_i   (cpu_clk),
        .rst_i   (cpu_rst),
        .flush_i (flush),
        .push_i  (upd_valid && upd_is_call),
        .pop_i   (upd_valid && upd_is_ret),
        .data_i  (upd_pc + ADDR_WIDTH'(4)),
        .top_o   (ras_top),
        .count_o (ras_cnt)
    );

    assign hit = rd_valid_q && (rd_tag_q == pc_tag);

    // Returns predict taken only when the stack has an address
    assign predict_taken = hit && (rd_ret_q ? (ras_cnt != '0)
                                            : rd_ctr_q[1]);

    assign predict_target_pc = !hit     ? '0      :
                               rd_ret_q ? ras_top : rd_tgt_q;

endmodule
